if_fetch_queue: RTL and testbench

- Instruction prefetch queue directly downstream of the fetch PC register.
- Accepts {PC, instruction} pairs from the IF stage and instruction memory, buffers up to DEPTH entries, and presents them in order to the decode stage.
- Absorbs decode stalls without stalling the PC register.
- Drops all buffered entries on a branch/jump flush.

---
 rtl/if_fetch_queue_pkg.sv | 22 ++
 rtl/if_fetch_queue_if.sv | 39 +++
 rtl/if_fetch_queue_mem.sv | 37 +++
 rtl/if_fetch_queue.sv | 123 ++++++++++++
 tb/tb_if_fetch_queue.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/if_fetch_queue_pkg.sv
// -----------------------------------------------------------------------------
// if_fetch_queue_pkg
// Shared pipeline definitions for the instruction prefetch queue.
//   NOP_INSTR     : instruction word shown to decode when nothing is valid
//   PC_W, INSTR_W : widths of the program counter and instruction word
//   PC_INCR       : sequential PC step (pop_pc4 = pop_pc + PC_INCR)
//   fetch_entry_t : one buffered {pc, instr} pair
// -----------------------------------------------------------------------------
package if_fetch_queue_pkg;

  localparam int PC_W    = 32;
  localparam int INSTR_W = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [PC_W-1:0]    PC_INCR   = 32'd4;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/if_fetch_queue_if.sv
// -----------------------------------------------------------------------------
// if_fetch_queue_if
// Handshake bundle between IF (producer), the prefetch queue and decode
// (consumer).
//   push_valid/push_pc/push_instr -> queue, push_ready <- queue
//   pop_ready -> queue, pop_valid/pop_pc/pop_pc4/pop_instr/count <- queue
// Modports:
//   master : the pipeline side (drives push_* and pop_ready)
//   slave  : the queue itself
// -----------------------------------------------------------------------------
interface if_fetch_queue_if #(
  parameter int PTR_W = 2
) ();
  import if_fetch_queue_pkg::*;

  logic               push_valid;
  logic [PC_W-1:0]    push_pc;
  logic [INSTR_W-1:0] push_instr;
  logic               push_ready;

  logic               pop_ready;
  logic               pop_valid;
  logic [PC_W-1:0]    pop_pc;
  logic [PC_W-1:0]    pop_pc4;
  logic [INSTR_W-1:0] pop_instr;

  logic [PTR_W:0]     count;

  modport master (
    output push_valid, push_pc, push_instr, pop_ready,
    input  push_ready, pop_valid, pop_pc, pop_pc4, pop_instr, count
  );

  modport slave (
    input  push_valid, push_pc, push_instr, pop_ready,
    output push_ready, pop_valid, pop_pc, pop_pc4, pop_instr, count
  );

endinterface

// File: rtl/if_fetch_queue_mem.sv
// -----------------------------------------------------------------------------
// if_fetch_queue_mem
// DEPTH x {pc, instr} register array for the prefetch queue.
//   clk   : write clock
//   we    : write enable (synchronous write at waddr)
//   waddr : write slot
//   wdata : entry to store
//   raddr : read slot
//   rdata : entry at raddr (asynchronous read, so the head is visible in the
//           same cycle the read pointer points at it)
// Storage is not reset; the queue's pointers/count decide what is valid.
// -----------------------------------------------------------------------------
module if_fetch_queue_mem
  import if_fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  fetch_entry_t     wdata,
  input  logic [PTR_W-1:0] raddr,
  output fetch_entry_t     rdata
);

  fetch_entry_t mem_reg [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_reg[waddr] <= wdata;
    end
  end

  assign rdata = mem_reg[raddr];

endmodule

// File: rtl/if_fetch_queue.sv
// -----------------------------------------------------------------------------
// if_fetch_queue
// Instruction prefetch queue between the fetch PC register and decode.
// Buffers up to DEPTH {pc, instr} pairs in a circular buffer, presents them in
// order, absorbs decode stalls and drops everything on a flush.
//   clk   : pipeline clock
//   rst   : synchronous active-high reset
//   flush : discard all entries (branch/jump redirect); same-cycle push/pop
//           are ignored
//   bus   : if_fetch_queue_if.slave (push_*, pop_*, count)
// Optional build macro IF_FETCH_QUEUE_BYPASS_EN: when the queue is empty and a
// push is offered, the push is shown on pop_* in the same cycle; if decode
// takes it, it is never written.
// -----------------------------------------------------------------------------
module if_fetch_queue
  import if_fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  if_fetch_queue_if.slave bus
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W:0]   cnt_reg, cnt_next;

  fetch_entry_t push_entry;
  fetch_entry_t head_entry;

  logic not_empty;
  logic push_fire;
  logic pop_fire;
  logic bypass_take;
  logic do_write;
  logic do_pop;

  assign push_entry = '{pc: bus.push_pc, instr: bus.push_instr};
  assign not_empty  = (cnt_reg != '0);

  // Depends only on registered occupancy: a pop in the same cycle does not
  // open a slot until the next cycle, keeping pop_ready off the PC enable path.
  assign bus.push_ready = (cnt_reg != FULL_CNT);

`ifdef IF_FETCH_QUEUE_BYPASS_EN
  logic bypass_active;
  assign bypass_active = !not_empty && bus.push_valid && !flush;

  assign bus.pop_valid = not_empty || bypass_active;
  assign bus.pop_pc    = not_empty     ? head_entry.pc    :
                         bypass_active ? bus.push_pc      : '0;
  assign bus.pop_instr = not_empty     ? head_entry.instr :
                         bypass_active ? bus.push_instr   : NOP_INSTR;
  // Entry consumed straight from the push port: neither stored nor popped.
  assign bypass_take   = bypass_active && bus.pop_ready;
`else
  assign bus.pop_valid = not_empty;
  assign bus.pop_pc    = not_empty ? head_entry.pc    : '0;
  assign bus.pop_instr = not_empty ? head_entry.instr : NOP_INSTR;
  assign bypass_take   = 1'b0;
`endif

  assign bus.pop_pc4 = bus.pop_pc + PC_INCR;
  assign bus.count   = cnt_reg;

  assign push_fire = bus.push_valid && bus.push_ready;
  assign pop_fire  = bus.pop_valid && bus.pop_ready;
  assign do_write  = push_fire && !bypass_take && !flush && !rst;
  assign do_pop    = pop_fire && !bypass_take;

  always_comb begin
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    cnt_next    = cnt_reg;
    // DEPTH is a power of two, so the natural overflow of the pointer
    // increment is the wrap from DEPTH-1 to 0.
    if (do_write) begin
      wr_ptr_next = wr_ptr_reg + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_next = rd_ptr_reg + 1'b1;
    end
    case ({do_write, do_pop})
      2'b10:   cnt_next = cnt_reg + 1'b1;
      2'b01:   cnt_next = cnt_reg - 1'b1;
      default: cnt_next = cnt_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      cnt_reg    <= '0;
    end else if (flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      cnt_reg    <= '0;
    end else begin
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      cnt_reg    <= cnt_next;
    end
  end

  if_fetch_queue_mem #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (do_write),
    .waddr (wr_ptr_reg),
    .wdata (push_entry),
    .raddr (rd_ptr_reg),
    .rdata (head_entry)
  );

endmodule

// File: tb/tb_if_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_if_fetch_queue
// Directed self-checking bench for if_fetch_queue (DEPTH=4). Inputs change 1ns
// after the rising edge, outputs are sampled 1ns later, away from the edge.
// Covers reset, fill/drain, back-to-back push/pop across pointer wraps, flush,
// full-with-pop, and the empty-queue push path (both IF_FETCH_QUEUE_BYPASS_EN
// builds).
// -----------------------------------------------------------------------------
module tb_if_fetch_queue;

  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic clk;
  logic rst;
  logic flush;

  int tests_run;
  int tests_failed;

  if_fetch_queue_if #(.PTR_W(PTR_W)) bus ();

  if_fetch_queue #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Pushes n entries with pc = base + 4*i, instr = ibase + i, decode stalled.
  task automatic push_n(input logic [31:0] base, input logic [31:0] ibase, input int n);
    for (int i = 0; i < n; i++) begin
      bus.push_valid = 1'b1;
      bus.push_pc    = base + 32'(4 * i);
      bus.push_instr = ibase + 32'(i);
      bus.pop_ready  = 1'b0;
      tick();
      $display("[TB] push pc=%08h instr=%08h", base + 32'(4 * i), ibase + 32'(i));
    end
    bus.push_valid = 1'b0;
  endtask

  task automatic test_reset();
    bus.push_valid = 1'b1;
    bus.push_pc    = 32'h80;
    bus.push_instr = 32'hDEAD_BEEF;
    bus.pop_ready  = 1'b0;
    flush          = 1'b0;
    rst            = 1'b1;
    tick();
    tick();
    rst            = 1'b0;
    bus.push_valid = 1'b0;
    settle();
    tests_run++;
    if (bus.count !== 3'd0) begin
      tests_failed++; $display("FAIL reset_count got=%0d exp=0", bus.count);
    end
    tests_run++;
    if (bus.pop_valid !== 1'b0) begin
      tests_failed++; $display("FAIL reset_pop_valid got=%b exp=0", bus.pop_valid);
    end
    tests_run++;
    if (bus.pop_instr !== 32'h0) begin
      tests_failed++; $display("FAIL reset_pop_instr got=%08h exp=00000000", bus.pop_instr);
    end
    tests_run++;
    if (bus.push_ready !== 1'b1) begin
      tests_failed++; $display("FAIL reset_push_ready got=%b exp=1", bus.push_ready);
    end
    tick();
    tests_run++;
    if (bus.count !== 3'd0 || bus.pop_valid !== 1'b0) begin
      tests_failed++; $display("FAIL reset_nothing_stored count=%0d pop_valid=%b exp 0/0", bus.count, bus.pop_valid);
    end
    $display("[TB] reset done");
  endtask

  task automatic test_fill_drain();
    push_n(32'h0, 32'h1000, 4);
    settle();
    tests_run++;
    if (bus.count !== 3'd4) begin
      tests_failed++; $display("FAIL fill_count got=%0d exp=4", bus.count);
    end
    tests_run++;
    if (bus.push_ready !== 1'b0) begin
      tests_failed++; $display("FAIL fill_push_ready got=%b exp=0", bus.push_ready);
    end
    // Fifth push while full must be ignored.
    bus.push_valid = 1'b1;
    bus.push_pc    = 32'h10;
    bus.push_instr = 32'h1004;
    tick();
    bus.push_valid = 1'b0;
    settle();
    tests_run++;
    if (bus.count !== 3'd4) begin
      tests_failed++; $display("FAIL fill_fifth_ignored count got=%0d exp=4", bus.count);
    end
    bus.pop_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      $display("[TB] pop pc=%08h pc4=%08h instr=%08h", bus.pop_pc, bus.pop_pc4, bus.pop_instr);
      tests_run++;
      if (bus.pop_valid !== 1'b1 || bus.pop_pc !== 32'(4 * i) || bus.pop_pc4 !== 32'(4 * i + 4) ||
          bus.pop_instr !== 32'h1000 + 32'(i) || bus.count !== 3'(4 - i)) begin
        tests_failed++;
        $display("FAIL drain_%0d got v=%b pc=%08h pc4=%08h instr=%08h cnt=%0d exp v=1 pc=%08h pc4=%08h instr=%08h cnt=%0d",
                 i, bus.pop_valid, bus.pop_pc, bus.pop_pc4, bus.pop_instr, bus.count,
                 32'(4 * i), 32'(4 * i + 4), 32'h1000 + 32'(i), 4 - i);
      end
      tick();
    end
    settle();
    tests_run++;
    if (bus.pop_valid !== 1'b0 || bus.pop_instr !== 32'h0 || bus.count !== 3'd0) begin
      tests_failed++;
      $display("FAIL drain_empty got v=%b instr=%08h cnt=%0d exp v=0 instr=0 cnt=0", bus.pop_valid, bus.pop_instr, bus.count);
    end
    bus.pop_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    push_n(32'h200, 32'h2000, 2);
    // Each cycle pushes pc 0x208+4k and pops 0x200+4k; 12 writes wrap 3 times.
    for (int k = 0; k < 10; k++) begin
      bus.push_valid = 1'b1;
      bus.push_pc    = 32'h208 + 32'(4 * k);
      bus.push_instr = 32'h2002 + 32'(k);
      bus.pop_ready  = 1'b1;
      settle();
      $display("[TB] push/pop in=%08h out=%08h cnt=%0d", bus.push_pc, bus.pop_pc, bus.count);
      tests_run++;
      if (bus.pop_pc !== 32'h200 + 32'(4 * k) || bus.pop_instr !== 32'h2000 + 32'(k) || bus.count !== 3'd2) begin
        tests_failed++;
        $display("FAIL b2b_%0d got pc=%08h instr=%08h cnt=%0d exp pc=%08h instr=%08h cnt=2",
                 k, bus.pop_pc, bus.pop_instr, bus.count, 32'h200 + 32'(4 * k), 32'h2000 + 32'(k));
      end
      tick();
    end
    bus.push_valid = 1'b0;
    for (int k = 10; k < 12; k++) begin
      settle();
      tests_run++;
      if (bus.pop_valid !== 1'b1 || bus.pop_pc !== 32'h200 + 32'(4 * k) || bus.pop_instr !== 32'h2000 + 32'(k)) begin
        tests_failed++;
        $display("FAIL b2b_tail_%0d got v=%b pc=%08h instr=%08h exp v=1 pc=%08h instr=%08h",
                 k, bus.pop_valid, bus.pop_pc, bus.pop_instr, 32'h200 + 32'(4 * k), 32'h2000 + 32'(k));
      end
      tick();
    end
    settle();
    tests_run++;
    if (bus.count !== 3'd0) begin
      tests_failed++; $display("FAIL b2b_final_count got=%0d exp=0", bus.count);
    end
    bus.pop_ready = 1'b0;
  endtask

  task automatic test_flush();
    push_n(32'h30, 32'h3000, 3);
    settle();
    tests_run++;
    if (bus.count !== 3'd3) begin
      tests_failed++; $display("FAIL flush_pre_count got=%0d exp=3", bus.count);
    end
    flush          = 1'b1;
    bus.push_valid = 1'b1;
    bus.push_pc    = 32'h40;
    bus.push_instr = 32'h4000;
    tick();
    flush          = 1'b0;
    bus.push_valid = 1'b0;
    settle();
    $display("[TB] flush cnt=%0d pop_valid=%b", bus.count, bus.pop_valid);
    tests_run++;
    if (bus.count !== 3'd0 || bus.pop_valid !== 1'b0 || bus.pop_instr !== 32'h0) begin
      tests_failed++;
      $display("FAIL flush_clear got cnt=%0d v=%b instr=%08h exp cnt=0 v=0 instr=0", bus.count, bus.pop_valid, bus.pop_instr);
    end
    bus.pop_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++;
      if (bus.pop_valid !== 1'b0 || bus.pop_pc === 32'h40) begin
        tests_failed++; $display("FAIL flush_no_ghost_%0d got v=%b pc=%08h exp v=0 pc!=00000040", i, bus.pop_valid, bus.pop_pc);
      end
    end
    bus.pop_ready = 1'b0;
  endtask

  task automatic test_full_pop();
    push_n(32'h400, 32'h4400, 4);
    bus.push_valid = 1'b1;
    bus.push_pc    = 32'h500;
    bus.push_instr = 32'h5000;
    bus.pop_ready  = 1'b1;
    settle();
    tests_run++;
    if (bus.push_ready !== 1'b0 || bus.pop_valid !== 1'b1 || bus.pop_pc !== 32'h400) begin
      tests_failed++;
      $display("FAIL full_pop_same got push_ready=%b v=%b pc=%08h exp 0/1/00000400", bus.push_ready, bus.pop_valid, bus.pop_pc);
    end
    tick();
    bus.push_valid = 1'b0;
    bus.pop_ready  = 1'b0;
    settle();
    $display("[TB] full_pop cnt=%0d push_ready=%b head=%08h", bus.count, bus.push_ready, bus.pop_pc);
    tests_run++;
    if (bus.push_ready !== 1'b1 || bus.count !== 3'd3 || bus.pop_pc !== 32'h404) begin
      tests_failed++;
      $display("FAIL full_pop_next got push_ready=%b cnt=%0d pc=%08h exp 1/3/00000404", bus.push_ready, bus.count, bus.pop_pc);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic test_bypass();
    bus.push_valid = 1'b1;
    bus.push_pc    = 32'h100;
    bus.push_instr = 32'h2008_0005;
    bus.pop_ready  = 1'b1;
    settle();
`ifdef IF_FETCH_QUEUE_BYPASS_EN
    tests_run++;
    if (bus.pop_valid !== 1'b1 || bus.pop_pc !== 32'h100 || bus.pop_instr !== 32'h2008_0005 ||
        bus.pop_pc4 !== 32'h104 || bus.count !== 3'd0) begin
      tests_failed++;
      $display("FAIL bypass_same got v=%b pc=%08h instr=%08h pc4=%08h cnt=%0d exp 1/00000100/20080005/00000104/0",
               bus.pop_valid, bus.pop_pc, bus.pop_instr, bus.pop_pc4, bus.count);
    end
    tick();
    bus.push_valid = 1'b0;
    bus.pop_ready  = 1'b0;
    settle();
    tests_run++;
    if (bus.count !== 3'd0 || bus.pop_valid !== 1'b0) begin
      tests_failed++; $display("FAIL bypass_consumed got cnt=%0d v=%b exp 0/0", bus.count, bus.pop_valid);
    end
`else
    tests_run++;
    if (bus.pop_valid !== 1'b0 || bus.pop_instr !== 32'h0) begin
      tests_failed++; $display("FAIL nobypass_same got v=%b instr=%08h exp 0/00000000", bus.pop_valid, bus.pop_instr);
    end
    tick();
    bus.push_valid = 1'b0;
    settle();
    tests_run++;
    if (bus.pop_valid !== 1'b1 || bus.pop_pc !== 32'h100 || bus.pop_instr !== 32'h2008_0005 ||
        bus.pop_pc4 !== 32'h104 || bus.count !== 3'd1) begin
      tests_failed++;
      $display("FAIL nobypass_next got v=%b pc=%08h instr=%08h pc4=%08h cnt=%0d exp 1/00000100/20080005/00000104/1",
               bus.pop_valid, bus.pop_pc, bus.pop_instr, bus.pop_pc4, bus.count);
    end
    tick();
    bus.pop_ready = 1'b0;
    settle();
    tests_run++;
    if (bus.count !== 3'd0) begin
      tests_failed++; $display("FAIL nobypass_drained got cnt=%0d exp 0", bus.count);
    end
`endif
    $display("[TB] bypass path pc=00000100 checked");
  endtask

  initial begin
    tests_run      = 0;
    tests_failed   = 0;
    rst            = 1'b1;
    flush          = 1'b0;
    bus.push_valid = 1'b0;
    bus.push_pc    = '0;
    bus.push_instr = '0;
    bus.pop_ready  = 1'b0;

    test_reset();
    test_fill_drain();
    test_back_to_back();
    test_flush();
    test_full_pop();
    test_bypass();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
